// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - FIFO pointer/flag controller driving a show-ahead storage RAM
// Optional almost-full/almost-empty thresholds under macro FIFO_CTRL_ALMOST_FLAGS_EN.
module fifo_ctrl #(
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  output logic             wr_ena,
  output logic             valid_write,
  output logic [DEPTH-1:0] wr_adb,
  output logic             rd_ena,
  output logic [DEPTH-1:0] rd_adb,
  output logic             full,
  output logic             empty,
  output logic [DEPTH:0]   count,
  output logic             overflow,
  output logic             underflow,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam logic [DEPTH:0] CAP = (DEPTH+1)'(1) << DEPTH;

  logic [DEPTH-1:0] wr_ptr;
  logic [DEPTH-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CAP);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Reset must never qualify a RAM write, even with push high.
  assign valid_write = push_ok & ~rst;
  assign wr_ena      = ~valid_write;
  assign wr_adb      = wr_ptr;

  assign rd_ena = empty;
  assign rd_adb = rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + DEPTH'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + DEPTH'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (DEPTH+1)'(1);
        2'b01:   count <= count - (DEPTH+1)'(1);
        default: count <= count;
      endcase
      if (push & full) overflow  <= 1'b1;
      if (pop & empty) underflow <= 1'b1;
    end
  end

`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
  localparam logic [DEPTH:0] AF_LEVEL = (DEPTH+1)'(2**DEPTH - AF_MARGIN);
  localparam logic [DEPTH:0] AE_LEVEL = (DEPTH+1)'(AE_MARGIN);

  assign almost_full  = (count >= AF_LEVEL);
  assign almost_empty = (count <= AE_LEVEL);
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - self-checking bench for fifo_ctrl with DEPTH=3
module tb_fifo_ctrl;

  localparam int DEPTH = 3;
  localparam int CAP   = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic             wr_ena;
  logic             valid_write;
  logic [DEPTH-1:0] wr_adb;
  logic             rd_ena;
  logic [DEPTH-1:0] rd_adb;
  logic             full;
  logic             empty;
  logic [DEPTH:0]   count;
  logic             overflow;
  logic             underflow;
  logic             almost_full;
  logic             almost_empty;

  int checks = 0;
  int failures = 0;

  fifo_ctrl #(.DEPTH(DEPTH), .AF_MARGIN(2), .AE_MARGIN(2)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .wr_ena(wr_ena), .valid_write(valid_write), .wr_adb(wr_adb),
    .rd_ena(rd_ena), .rd_adb(rd_adb), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow),
    .almost_full(almost_full), .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  // Model: the FIFO contents as a queue of tags, plus lifetime accept totals.
  int q[$];
  int wr_total = 0;
  int rd_total = 0;
  int tag = 0;
  bit m_ovf = 0;
  bit m_unf = 0;
  bit model_live = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      wr_total = 0;
      rd_total = 0;
      m_ovf = 0;
      m_unf = 0;
      model_live = 1;
    end else begin
      int sz;
      sz = q.size();
      if (push && sz == CAP) m_ovf = 1;
      if (pop && sz == 0) m_unf = 1;
      if (pop && sz > 0) begin
        void'(q.pop_front());
        rd_total++;
      end
      if (push && sz < CAP) begin
        q.push_back(tag);
        tag++;
        wr_total++;
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      int sz;
      int exp_af;
      int exp_ae;
      bit acc;
      sz = q.size();
      acc = push && (sz < CAP) && !rst;
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
      exp_af = (sz >= CAP - 2) ? 1 : 0;
      exp_ae = (sz <= 2) ? 1 : 0;
`else
      exp_af = 0;
      exp_ae = 0;
`endif
      check("count", int'(count), sz);
      check("full", int'(full), (sz == CAP) ? 1 : 0);
      check("empty", int'(empty), (sz == 0) ? 1 : 0);
      check("rd_ena", int'(rd_ena), (sz == 0) ? 1 : 0);
      check("valid_write", int'(valid_write), int'(acc));
      check("wr_ena", int'(wr_ena), int'(!acc));
      check("wr_adb", int'(wr_adb), wr_total % CAP);
      check("rd_adb", int'(rd_adb), rd_total % CAP);
      check("overflow", int'(overflow), int'(m_ovf));
      check("underflow", int'(underflow), int'(m_unf));
      check("almost_full", int'(almost_full), exp_af);
      check("almost_empty", int'(almost_empty), exp_ae);
    end
  end

  task automatic cyc(input bit p, input bit r, input bit s);
    push = p;
    pop = r;
    rst = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    check("lit_reset_count", int'(count), 0);
    check("lit_reset_empty", int'(empty), 1);
    check("lit_reset_rd_ena", int'(rd_ena), 1);
    check("lit_reset_wr_ena", int'(wr_ena), 1);
    check("lit_reset_valid_write", int'(valid_write), 0);
    check("lit_reset_adb", int'(rd_adb) + int'(wr_adb), 0);

    for (int i = 0; i < 8; i++) cyc(1, 0, 0);
    check("lit_full_count", int'(count), 8);
    check("lit_full_flag", int'(full), 1);
    push = 1;
    #1;
    check("lit_ninth_wr_ena", int'(wr_ena), 1);
    check("lit_ninth_valid_write", int'(valid_write), 0);
    check("lit_ninth_wr_adb", int'(wr_adb), 0);
    cyc(1, 0, 0);
    check("lit_overflow", int'(overflow), 1);

    for (int i = 0; i < 8; i++) begin
      check("lit_pop_rd_adb", int'(rd_adb), i);
      cyc(0, 1, 0);
    end
    check("lit_drain_rd_adb", int'(rd_adb), 0);
    check("lit_drain_empty", int'(empty), 1);
    cyc(0, 1, 0);
    check("lit_underflow", int'(underflow), 1);
    check("lit_underflow_rd_ena", int'(rd_ena), 1);

    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, 0);
    check("lit_steady_count", int'(count), 3);
    check("lit_steady_wr_adb", int'(wr_adb), 5);
    check("lit_steady_rd_adb", int'(rd_adb), 2);

    for (int i = 0; i < 5; i++) cyc(1, 0, 0);
    check("lit_refull_count", int'(count), 8);
    cyc(1, 1, 0);
    check("lit_full_pushpop_count", int'(count), 7);
    for (int i = 0; i < 7; i++) cyc(0, 1, 0);
    check("lit_redrain_count", int'(count), 0);
    cyc(1, 1, 0);
    check("lit_empty_pushpop_count", int'(count), 1);

    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    check("lit_pre_reset_count", int'(count), 5);
    push = 1;
    rst = 1;
    #1;
    check("lit_rst_valid_write", int'(valid_write), 0);
    check("lit_rst_wr_ena", int'(wr_ena), 1);
    cyc(1, 0, 1);
    check("lit_post_rst_count", int'(count), 0);
    check("lit_post_rst_overflow", int'(overflow), 0);
    cyc(0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0);
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
      check("lit_almost_full", int'(almost_full), (i + 1 >= 6) ? 1 : 0);
      check("lit_almost_empty", int'(almost_empty), (i + 1 <= 2) ? 1 : 0);
`else
      check("lit_almost_full", int'(almost_full), 0);
      check("lit_almost_empty", int'(almost_empty), 0);
`endif
    end
    for (int i = 0; i < 9; i++) cyc(0, 1, 0);
    cyc(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
